// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, functs,
// ALU operations, FSM states and datapath mux selects.
package mips_ctrl_pkg;

  localparam int unsigned OP_W     = 6;
  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned SEL_W    = 2;
  localparam int unsigned STATE_W  = 4;
  localparam int unsigned CNT_W    = 32;

  typedef logic [STATE_W-1:0] state_t;
  typedef logic [SEL_W-1:0]   sel_t;
  typedef logic [OP_W-1:0]    op_t;
  typedef logic [ALU_OP_W-1:0] alu_op_t;

  localparam state_t S_FETCH    = 4'd0;
  localparam state_t S_DECODE   = 4'd1;
  localparam state_t S_EXEC_R   = 4'd2;
  localparam state_t S_EXEC_I   = 4'd3;
  localparam state_t S_MEM_ADDR = 4'd4;
  localparam state_t S_MEM_RD   = 4'd5;
  localparam state_t S_MEM_WR   = 4'd6;
  localparam state_t S_WB_MEM   = 4'd7;
  localparam state_t S_WB_ALU   = 4'd8;
  localparam state_t S_BRANCH   = 4'd9;
  localparam state_t S_JUMP     = 4'd10;
  localparam state_t S_TRAP     = 4'd11;

  localparam op_t OP_RTYPE = 6'h00;
  localparam op_t OP_J     = 6'h02;
  localparam op_t OP_JAL   = 6'h03;
  localparam op_t OP_BEQ   = 6'h04;
  localparam op_t OP_BNE   = 6'h05;
  localparam op_t OP_ADDI  = 6'h08;
  localparam op_t OP_SLTI  = 6'h0A;
  localparam op_t OP_ANDI  = 6'h0C;
  localparam op_t OP_ORI   = 6'h0D;
  localparam op_t OP_XORI  = 6'h0E;
  localparam op_t OP_LW    = 6'h23;
  localparam op_t OP_SW    = 6'h2B;

  localparam op_t FN_SLL = 6'h00;
  localparam op_t FN_SRL = 6'h02;
  localparam op_t FN_JR  = 6'h08;
  localparam op_t FN_ADD = 6'h20;
  localparam op_t FN_SUB = 6'h22;
  localparam op_t FN_AND = 6'h24;
  localparam op_t FN_OR  = 6'h25;
  localparam op_t FN_XOR = 6'h26;
  localparam op_t FN_NOR = 6'h27;
  localparam op_t FN_SGT = 6'h29;
  localparam op_t FN_SLT = 6'h2A;

  localparam alu_op_t ALU_ADD  = 4'b0000;
  localparam alu_op_t ALU_SUB  = 4'b0001;
  localparam alu_op_t ALU_AND  = 4'b0010;
  localparam alu_op_t ALU_OR   = 4'b0011;
  localparam alu_op_t ALU_SLT  = 4'b0100;
  localparam alu_op_t ALU_XOR  = 4'b0101;
  localparam alu_op_t ALU_NOR  = 4'b0110;
  localparam alu_op_t ALU_SLL  = 4'b0111;
  localparam alu_op_t ALU_SRL  = 4'b1000;
  localparam alu_op_t ALU_SGT  = 4'b1001;
  localparam alu_op_t ALU_NONE = 4'b1111;

  localparam sel_t PC_SRC_ALU    = 2'd0;
  localparam sel_t PC_SRC_ALUOUT = 2'd1;
  localparam sel_t PC_SRC_JUMP   = 2'd2;
  localparam sel_t PC_SRC_RS     = 2'd3;

  localparam sel_t REG_DST_RT = 2'd0;
  localparam sel_t REG_DST_RD = 2'd1;
  localparam sel_t REG_DST_RA = 2'd2;

  localparam sel_t M2R_ALUOUT = 2'd0;
  localparam sel_t M2R_MDR    = 2'd1;
  localparam sel_t M2R_PC     = 2'd2;

  localparam sel_t SRC_A_PC    = 2'd0;
  localparam sel_t SRC_A_RS    = 2'd1;
  localparam sel_t SRC_A_SHAMT = 2'd2;

  localparam sel_t SRC_B_RT     = 2'd0;
  localparam sel_t SRC_B_FOUR   = 2'd1;
  localparam sel_t SRC_B_IMM    = 2'd2;
  localparam sel_t SRC_B_BR_OFF = 2'd3;

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational opcode/funct decode: ALU operation, immediate extension
// mode and a legality flag used for DECODE dispatch.
module mips_alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [OP_W-1:0]     opcode_i,
  input  logic [OP_W-1:0]     funct_i,
  output logic [ALU_OP_W-1:0] alu_op_o,
  output logic                imm_zext_o,
  output logic                valid_o
);

  always_comb begin
    alu_op_o   = ALU_NONE;
    imm_zext_o = 1'b0;
    valid_o    = 1'b1;
    case (opcode_i)
      OP_RTYPE: begin
        case (funct_i)
          FN_ADD:  alu_op_o = ALU_ADD;
          FN_SUB:  alu_op_o = ALU_SUB;
          FN_AND:  alu_op_o = ALU_AND;
          FN_OR:   alu_op_o = ALU_OR;
          FN_XOR:  alu_op_o = ALU_XOR;
          FN_NOR:  alu_op_o = ALU_NOR;
          FN_SLT:  alu_op_o = ALU_SLT;
          FN_SGT:  alu_op_o = ALU_SGT;
          FN_SLL:  alu_op_o = ALU_SLL;
          FN_SRL:  alu_op_o = ALU_SRL;
          FN_JR:   alu_op_o = ALU_NONE;
          default: valid_o  = 1'b0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: alu_op_o = ALU_ADD;
      OP_SLTI:               alu_op_o = ALU_SLT;
      OP_ANDI: begin
        alu_op_o   = ALU_AND;
        imm_zext_o = 1'b1;
      end
      OP_ORI: begin
        alu_op_o   = ALU_OR;
        imm_zext_o = 1'b1;
      end
      OP_XORI: begin
        alu_op_o   = ALU_XOR;
        imm_zext_o = 1'b1;
      end
      OP_BEQ, OP_BNE: alu_op_o = ALU_SUB;
      OP_J, OP_JAL:   alu_op_o = ALU_NONE;
      default:        valid_o  = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS sequencer driving the shared datapath and unified memory.
// Optional MIPS_CTRL_PERF_EN adds cycle/retired-instruction counters.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [OP_W-1:0]     opcode_i,
  input  logic [OP_W-1:0]     funct_i,
  input  logic                zero_i,
  input  logic                mem_ready_i,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic                iord_o,
  output logic                ir_wr_en_o,
  output logic                pc_wr_en_o,
  output logic [SEL_W-1:0]    pc_src_o,
  output logic                reg_wr_en_o,
  output logic [SEL_W-1:0]    reg_dst_o,
  output logic [SEL_W-1:0]    mem_to_reg_o,
  output logic [SEL_W-1:0]    alu_src_a_o,
  output logic [SEL_W-1:0]    alu_src_b_o,
  output logic                imm_zext_o,
  output logic [ALU_OP_W-1:0] alu_op_o,
  output logic                instr_done_o,
  output logic                invalid_inst_o
`ifdef MIPS_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]    cycle_cnt_o,
  output logic [CNT_W-1:0]    retired_cnt_o
`endif
);

  state_t              state_q, state_d;
  logic [ALU_OP_W-1:0] dec_alu_op;
  logic                dec_imm_zext;
  logic                dec_valid;
  logic                is_rtype;
  logic                is_shift;

  mips_alu_decoder u_dec (
    .opcode_i   (opcode_i),
    .funct_i    (funct_i),
    .alu_op_o   (dec_alu_op),
    .imm_zext_o (dec_imm_zext),
    .valid_o    (dec_valid)
  );

  assign is_rtype = (opcode_i == OP_RTYPE);
  assign is_shift = is_rtype && ((funct_i == FN_SLL) || (funct_i == FN_SRL));

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Outputs are Mealy on mem_ready/zero and forced idle while rst is high.
  always_comb begin
    state_d        = state_q;
    mem_req_o      = 1'b0;
    mem_we_o       = 1'b0;
    iord_o         = 1'b0;
    ir_wr_en_o     = 1'b0;
    pc_wr_en_o     = 1'b0;
    pc_src_o       = PC_SRC_ALU;
    reg_wr_en_o    = 1'b0;
    reg_dst_o      = REG_DST_RT;
    mem_to_reg_o   = M2R_ALUOUT;
    alu_src_a_o    = SRC_A_PC;
    alu_src_b_o    = SRC_B_RT;
    imm_zext_o     = 1'b0;
    alu_op_o       = ALU_NONE;
    instr_done_o   = 1'b0;
    invalid_inst_o = 1'b0;
    if (!rst_i) begin
      case (state_q)
        S_FETCH: begin
          mem_req_o   = 1'b1;
          alu_src_a_o = SRC_A_PC;
          alu_src_b_o = SRC_B_FOUR;
          alu_op_o    = ALU_ADD;
          if (mem_ready_i) begin
            ir_wr_en_o = 1'b1;
            pc_wr_en_o = 1'b1;
            state_d    = S_DECODE;
          end
        end
        S_DECODE: begin
          alu_src_a_o = SRC_A_PC;
          alu_src_b_o = SRC_B_BR_OFF;
          alu_op_o    = ALU_ADD;
          if (!dec_valid) state_d = S_TRAP;
          else begin
            case (opcode_i)
              OP_RTYPE:       state_d = (funct_i == FN_JR) ? S_JUMP : S_EXEC_R;
              OP_LW, OP_SW:   state_d = S_MEM_ADDR;
              OP_BEQ, OP_BNE: state_d = S_BRANCH;
              OP_J, OP_JAL:   state_d = S_JUMP;
              default:        state_d = S_EXEC_I;
            endcase
          end
        end
        S_EXEC_R: begin
          alu_src_a_o = is_shift ? SRC_A_SHAMT : SRC_A_RS;
          alu_src_b_o = SRC_B_RT;
          alu_op_o    = dec_alu_op;
          state_d     = S_WB_ALU;
        end
        S_EXEC_I: begin
          alu_src_a_o = SRC_A_RS;
          alu_src_b_o = SRC_B_IMM;
          imm_zext_o  = dec_imm_zext;
          alu_op_o    = dec_alu_op;
          state_d     = S_WB_ALU;
        end
        S_WB_ALU: begin
          reg_wr_en_o  = 1'b1;
          reg_dst_o    = is_rtype ? REG_DST_RD : REG_DST_RT;
          mem_to_reg_o = M2R_ALUOUT;
          instr_done_o = 1'b1;
          state_d      = S_FETCH;
        end
        S_MEM_ADDR: begin
          alu_src_a_o = SRC_A_RS;
          alu_src_b_o = SRC_B_IMM;
          alu_op_o    = ALU_ADD;
          state_d     = (opcode_i == OP_LW) ? S_MEM_RD : S_MEM_WR;
        end
        S_MEM_RD: begin
          mem_req_o = 1'b1;
          iord_o    = 1'b1;
          if (mem_ready_i) state_d = S_WB_MEM;
        end
        S_WB_MEM: begin
          reg_wr_en_o  = 1'b1;
          reg_dst_o    = REG_DST_RT;
          mem_to_reg_o = M2R_MDR;
          instr_done_o = 1'b1;
          state_d      = S_FETCH;
        end
        S_MEM_WR: begin
          mem_req_o = 1'b1;
          mem_we_o  = 1'b1;
          iord_o    = 1'b1;
          if (mem_ready_i) begin
            instr_done_o = 1'b1;
            state_d      = S_FETCH;
          end
        end
        S_BRANCH: begin
          alu_src_a_o  = SRC_A_RS;
          alu_src_b_o  = SRC_B_RT;
          alu_op_o     = ALU_SUB;
          pc_src_o     = PC_SRC_ALUOUT;
          pc_wr_en_o   = (opcode_i == OP_BEQ) ? zero_i : !zero_i;
          instr_done_o = 1'b1;
          state_d      = S_FETCH;
        end
        S_JUMP: begin
          pc_wr_en_o   = 1'b1;
          instr_done_o = 1'b1;
          pc_src_o     = is_rtype ? PC_SRC_RS : PC_SRC_JUMP;
          if (opcode_i == OP_JAL) begin
            reg_wr_en_o  = 1'b1;
            reg_dst_o    = REG_DST_RA;
            mem_to_reg_o = M2R_PC;
          end
          state_d = S_FETCH;
        end
        S_TRAP: invalid_inst_o = 1'b1;
        default: state_d = S_FETCH;
      endcase
    end
  end

`ifdef MIPS_CTRL_PERF_EN
  logic [CNT_W-1:0] cycle_cnt_q, retired_cnt_q;

  // Cycle counter freezes in TRAP; both wrap naturally.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cycle_cnt_q   <= '0;
      retired_cnt_q <= '0;
    end else begin
      if (state_q != S_TRAP) cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
      if (instr_done_o)      retired_cnt_q <= retired_cnt_q + CNT_W'(1);
    end
  end

  assign cycle_cnt_o   = cycle_cnt_q;
  assign retired_cnt_o = retired_cnt_q;
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl; also covers MIPS_CTRL_PERF_EN.
module tb_mips_multicycle_ctrl;

  localparam int unsigned OV_W = 23;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = '0, funct = '0;
  logic       zero = 1'b0, mem_ready = 1'b0;

  logic       mem_req, mem_we, iord, ir_wr_en, pc_wr_en, reg_wr_en;
  logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_a, alu_src_b;
  logic       imm_zext, instr_done, invalid_inst;
  logic [3:0] alu_op;
`ifdef MIPS_CTRL_PERF_EN
  logic [31:0] cycle_cnt, retired_cnt;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  mips_multicycle_ctrl dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .opcode_i       (opcode),
    .funct_i        (funct),
    .zero_i         (zero),
    .mem_ready_i    (mem_ready),
    .mem_req_o      (mem_req),
    .mem_we_o       (mem_we),
    .iord_o         (iord),
    .ir_wr_en_o     (ir_wr_en),
    .pc_wr_en_o     (pc_wr_en),
    .pc_src_o       (pc_src),
    .reg_wr_en_o    (reg_wr_en),
    .reg_dst_o      (reg_dst),
    .mem_to_reg_o   (mem_to_reg),
    .alu_src_a_o    (alu_src_a),
    .alu_src_b_o    (alu_src_b),
    .imm_zext_o     (imm_zext),
    .alu_op_o       (alu_op),
    .instr_done_o   (instr_done),
    .invalid_inst_o (invalid_inst)
`ifdef MIPS_CTRL_PERF_EN
    ,
    .cycle_cnt_o    (cycle_cnt),
    .retired_cnt_o  (retired_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [OV_W-1:0] obs;
  assign obs = {mem_req, mem_we, iord, ir_wr_en, pc_wr_en, pc_src, reg_wr_en,
                reg_dst, mem_to_reg, alu_src_a, alu_src_b, imm_zext, alu_op,
                instr_done, invalid_inst};

  function automatic logic [OV_W-1:0] ov(
    input logic mreq, mwe, io, irw, pcw, input logic [1:0] pcs,
    input logic rw, input logic [1:0] rd, m2r, sa, sb,
    input logic zx, input logic [3:0] aop, input logic done, inv);
    return {mreq, mwe, io, irw, pcw, pcs, rw, rd, m2r, sa, sb, zx, aop, done, inv};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, then check outputs.
  task automatic cyc(input logic r, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input logic rdy,
                     input logic [OV_W-1:0] e, input string tag);
    @(negedge clk);
    rst = r; opcode = op; funct = fn; zero = z; mem_ready = rdy;
    #1;
    chk(tag, 32'(obs), 32'(e));
  endtask

  logic [OV_W-1:0] IDLE, F_RDY, F_WAIT, DEC, WB_R, WB_I;

  initial begin
    IDLE   = ov(0,0,0,0,0,2'd0,0,2'd0,2'd0,2'd0,2'd0,0,4'hF,0,0);
    F_RDY  = ov(1,0,0,1,1,2'd0,0,2'd0,2'd0,2'd0,2'd1,0,4'h0,0,0);
    F_WAIT = ov(1,0,0,0,0,2'd0,0,2'd0,2'd0,2'd0,2'd1,0,4'h0,0,0);
    DEC    = ov(0,0,0,0,0,2'd0,0,2'd0,2'd0,2'd0,2'd3,0,4'h0,0,0);
    WB_R   = ov(0,0,0,0,0,2'd0,1,2'd1,2'd0,2'd0,2'd0,0,4'hF,1,0);
    WB_I   = ov(0,0,0,0,0,2'd0,1,2'd0,2'd0,2'd0,2'd0,0,4'hF,1,0);

    cyc(1, 6'h00, 6'h20, 0, 1, IDLE, "reset0");
    cyc(1, 6'h00, 6'h20, 0, 1, IDLE, "reset1");

    // add, no wait states
    cyc(0, 6'h00, 6'h20, 0, 1, F_RDY, "add_fetch");
    cyc(0, 6'h00, 6'h20, 0, 1, DEC, "add_decode");
    cyc(0, 6'h00, 6'h20, 0, 1, ov(0,0,0,0,0,2'd0,0,2'd0,2'd0,2'd1,2'd0,0,4'h0,0,0), "add_exec");
    cyc(0, 6'h00, 6'h20, 0, 1, WB_R, "add_wb");

    // lw, two wait states per access
    cyc(0, 6'h23, 6'h00, 0, 0, F_WAIT, "lw_fetch_w1");
    cyc(0, 6'h23, 6'h00, 0, 0, F_WAIT, "lw_fetch_w2");
    cyc(0, 6'h23, 6'h00, 0, 1, F_RDY, "lw_fetch_rdy");
    cyc(0, 6'h23, 6'h00, 0, 1, DEC, "lw_decode");
    cyc(0, 6'h23, 6'h00, 0, 1, ov(0,0,0,0,0,2'd0,0,2'd0,2'd0,2'd1,2'd2,0,4'h0,0,0), "lw_addr");
    cyc(0, 6'h23, 6'h00, 0, 0, ov(1,0,1,0,0,2'd0,0,2'd0,2'd0,2'd0,2'd0,0,4'hF,0,0), "lw_rd_w1");
    cyc(0, 6'h23, 6'h00, 0, 0, ov(1,0,1,0,0,2'd0,0,2'd0,2'd0,2'd0,2'd0,0,4'hF,0,0), "lw_rd_w2");
    cyc(0, 6'h23, 6'h00, 0, 1, ov(1,0,1,0,0,2'd0,0,2'd0,2'd0,2'd0,2'd0,0,4'hF,0,0), "lw_rd_rdy");
    cyc(0, 6'h23, 6'h00, 0, 1, ov(0,0,0,0,0,2'd0,1,2'd0,2'd1,2'd0,2'd0,0,4'hF,1,0), "lw_wb");

    // beq taken, beq not taken, bne taken
    cyc(0, 6'h04, 6'h00, 1, 1, F_RDY, "beq1_fetch");
    cyc(0, 6'h04, 6'h00, 1, 0, DEC, "beq1_decode");
    cyc(0, 6'h04, 6'h00, 1, 0, ov(0,0,0,0,1,2'd1,0,2'd0,2'd0,2'd1,2'd0,0,4'h1,1,0), "beq_taken");
    cyc(0, 6'h04, 6'h00, 0, 1, F_RDY, "beq0_fetch");
    cyc(0, 6'h04, 6'h00, 0, 1, DEC, "beq0_decode");
    cyc(0, 6'h04, 6'h00, 0, 1, ov(0,0,0,0,0,2'd1,0,2'd0,2'd0,2'd1,2'd0,0,4'h1,1,0), "beq_not_taken");
    cyc(0, 6'h05, 6'h00, 0, 1, F_RDY, "bne_fetch");
    cyc(0, 6'h05, 6'h00, 0, 1, DEC, "bne_decode");
    cyc(0, 6'h05, 6'h00, 0, 1, ov(0,0,0,0,1,2'd1,0,2'd0,2'd0,2'd1,2'd0,0,4'h1,1,0), "bne_taken");

    // jal and jr
    cyc(0, 6'h03, 6'h00, 0, 1, F_RDY, "jal_fetch");
    cyc(0, 6'h03, 6'h00, 0, 1, DEC, "jal_decode");
    cyc(0, 6'h03, 6'h00, 0, 1, ov(0,0,0,0,1,2'd2,1,2'd2,2'd2,2'd0,2'd0,0,4'hF,1,0), "jal_jump");
    cyc(0, 6'h00, 6'h08, 0, 1, F_RDY, "jr_fetch");
    cyc(0, 6'h00, 6'h08, 0, 1, DEC, "jr_decode");
    cyc(0, 6'h00, 6'h08, 0, 1, ov(0,0,0,0,1,2'd3,0,2'd0,2'd0,2'd0,2'd0,0,4'hF,1,0), "jr_jump");

    // sll uses shamt, andi zero-extends
    cyc(0, 6'h00, 6'h00, 0, 1, F_RDY, "sll_fetch");
    cyc(0, 6'h00, 6'h00, 0, 1, DEC, "sll_decode");
    cyc(0, 6'h00, 6'h00, 0, 1, ov(0,0,0,0,0,2'd0,0,2'd0,2'd0,2'd2,2'd0,0,4'h7,0,0), "sll_exec");
    cyc(0, 6'h00, 6'h00, 0, 1, WB_R, "sll_wb");
    cyc(0, 6'h0C, 6'h00, 0, 1, F_RDY, "andi_fetch");
    cyc(0, 6'h0C, 6'h00, 0, 1, DEC, "andi_decode");
    cyc(0, 6'h0C, 6'h00, 0, 1, ov(0,0,0,0,0,2'd0,0,2'd0,2'd0,2'd1,2'd2,1,4'h2,0,0), "andi_exec");
    cyc(0, 6'h0C, 6'h00, 0, 1, WB_I, "andi_wb");

    // sw interrupted by reset during its memory wait
    cyc(0, 6'h2B, 6'h00, 0, 1, F_RDY, "sw_fetch");
    cyc(0, 6'h2B, 6'h00, 0, 1, DEC, "sw_decode");
    cyc(0, 6'h2B, 6'h00, 0, 1, ov(0,0,0,0,0,2'd0,0,2'd0,2'd0,2'd1,2'd2,0,4'h0,0,0), "sw_addr");
    cyc(0, 6'h2B, 6'h00, 0, 0, ov(1,1,1,0,0,2'd0,0,2'd0,2'd0,2'd0,2'd0,0,4'hF,0,0), "sw_wr_wait");
`ifdef MIPS_CTRL_PERF_EN
    chk("cycle_cnt_pre", cycle_cnt, 32'd39);
    chk("retired_cnt_pre", retired_cnt, 32'd9);
`endif
    cyc(1, 6'h2B, 6'h00, 0, 0, IDLE, "sw_rst_assert");
    cyc(1, 6'h2B, 6'h00, 0, 1, IDLE, "sw_rst_hold");
`ifdef MIPS_CTRL_PERF_EN
    chk("cycle_cnt_rst", cycle_cnt, 32'd0);
    chk("retired_cnt_rst", retired_cnt, 32'd0);
`endif

    // illegal opcode traps and only reset recovers
    cyc(0, 6'h3F, 6'h00, 0, 1, F_RDY, "trap_fetch");
    cyc(0, 6'h3F, 6'h00, 0, 1, DEC, "trap_decode");
    cyc(0, 6'h3F, 6'h00, 0, 1, IDLE | OV_W'(1), "trap_c3");
`ifdef MIPS_CTRL_PERF_EN
    chk("cycle_cnt_trap1", cycle_cnt, 32'd2);
`endif
    cyc(0, 6'h00, 6'h20, 0, 1, IDLE | OV_W'(1), "trap_c4");
`ifdef MIPS_CTRL_PERF_EN
    chk("cycle_cnt_trap2", cycle_cnt, 32'd2);
`endif
    cyc(1, 6'h00, 6'h20, 0, 0, IDLE, "trap_rst");
    cyc(0, 6'h00, 6'h20, 0, 0, F_WAIT, "trap_refetch");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
